// File: rtl/alu_issue.sv
// alu_issue: decodes MIPS-style ALU instructions and issues them through a
// 2-entry output/skid register pair so that in_ready never depends on out_ready.
module alu_issue #(
    parameter logic [5:0] NAND_FUNCT = 6'h28,
    parameter logic [3:0] ILLEGAL_OP = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [15:0] imm,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic        illegal
);
    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
    } entry_t;

    entry_t      w_dec, r_out, r_skid;
    logic        r_ov, r_sv;
    logic        w_hit, w_acc, w_iss;
    logic [3:0]  w_code;
    logic [31:0] w_b;

    always_comb begin
        w_hit  = 1'b1;
        w_code = 4'd0;
        w_b    = rt_val;
        case (opcode)
            6'h00: case (funct)
                6'h20, 6'h21: w_code = 4'd2;
                6'h22, 6'h23: w_code = 4'd6;
                6'h24:        w_code = 4'd0;
                6'h25:        w_code = 4'd1;
                6'h26:        w_code = 4'd13;
                6'h27:        w_code = 4'd12;
                default: begin
                    w_hit  = (funct == NAND_FUNCT);
                    w_code = 4'd7;
                end
            endcase
            6'h08, 6'h09, 6'h23, 6'h2B: begin
                w_code = 4'd2;
                w_b    = {{16{imm[15]}}, imm};
            end
            6'h0C, 6'h0D, 6'h0E: begin
                w_code = (opcode == 6'h0C) ? 4'd0 : (opcode == 6'h0D) ? 4'd1 : 4'd13;
                w_b    = {16'h0000, imm};
            end
            6'h04, 6'h05: w_code = 4'd6;
            default: w_hit = 1'b0;
        endcase
        w_dec = w_hit ? {w_code, rs_val, w_b, 1'b0} : {ILLEGAL_OP, 32'd0, 32'd0, 1'b1};
    end

    assign w_acc     = in_valid && !r_sv;
    assign w_iss     = r_ov && out_ready;
    assign in_ready  = !r_sv;
    assign out_valid = r_ov;
    assign alu_op    = r_out.op;
    assign a         = r_out.a;
    assign b         = r_out.b;
    assign illegal   = r_out.ill;

    // in_ready is low whenever skid is full, so accept and skid drain never coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ov   <= 1'b0;
            r_sv   <= 1'b0;
            r_out  <= '0;
            r_skid <= '0;
        end else if (flush) begin
            r_ov <= 1'b0;
            r_sv <= 1'b0;
        end else if (r_sv) begin
            if (w_iss) begin
                r_out <= r_skid;
                r_sv  <= 1'b0;
            end
        end else if (w_acc) begin
            if (!r_ov || w_iss) begin
                r_out <= w_dec;
                r_ov  <= 1'b1;
            end else begin
                r_skid <= w_dec;
                r_sv   <= 1'b1;
            end
        end else if (w_iss) begin
            r_ov <= 1'b0;
        end
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have parameter NAND_FUNCT, default 6'h28, the R-type funct code decoded as nand.
REQ-002 SHALL have parameter ILLEGAL_OP, default 4'd15, the alu_op value emitted for undecodable instructions.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream decode stage presents an instruction.
REQ-006 in_ready  output  1  block can accept an instruction this cycle.
REQ-007 opcode  input  6  instruction bits [31:26].
REQ-008 funct  input  6  instruction bits [5:0].
REQ-009 rs_val  input  32  rs register value.
REQ-010 rt_val  input  32  rt register value.
REQ-011 imm  input  16  instruction bits [15:0].
REQ-012 flush  input  1  synchronous pipeline kill.
REQ-013 out_valid  output  1  issued ALU operation valid.
REQ-014 out_ready  input  1  execute stage consumes the operation.
REQ-015 alu_op  output  4  ALU operation code.
REQ-016 a  output  32  ALU operand a.
REQ-017 b  output  32  ALU operand b.
REQ-018 illegal  output  1  issued instruction was not decodable.

Function
REQ-019 SHALL decode opcode 0 by funct: 0x20/0x21 -> 2 (add), 0x22/0x23 -> 6 (sub), 0x24 -> 0 (and), 0x25 -> 1 (or), 0x26 -> 13 (xor), 0x27 -> 12 (nor), NAND_FUNCT -> 7 (nand); b = rt_val.
REQ-020 SHALL decode addi 0x08, addiu 0x09, lw 0x23, sw 0x2B -> 2, b = sign-extended imm.
REQ-021 SHALL decode andi 0x0C -> 0, ori 0x0D -> 1, xori 0x0E -> 13, b = zero-extended imm.
REQ-022 SHALL decode beq 0x04, bne 0x05 -> 6, b = rt_val.
REQ-023 SHALL set a = rs_val for every decoded instruction.
REQ-024 Any other opcode/funct SHALL issue alu_op = ILLEGAL_OP, a = 0, b = 0, illegal = 1; otherwise illegal = 0.
REQ-025 Accept occurs when in_valid && in_ready; issue occurs when out_valid && out_ready.
REQ-026 SHALL contain an output register plus one skid register (2-entry capacity), preserving order.
REQ-027 in_ready SHALL equal NOT skid_valid, driven from a register (no combinational path from out_ready).
REQ-028 Accepted entry SHALL appear on outputs the next cycle if the output register is empty or issuing that cycle; otherwise it SHALL go to the skid register.
REQ-029 On issue with skid full, skid entry SHALL move to output register next cycle and skid SHALL empty.
REQ-030 Simultaneous accept and issue with skid empty SHALL load the new entry into the output register (out_valid stays 1).
REQ-031 While out_valid && !out_ready, alu_op, a, b, illegal SHALL remain stable.
REQ-032 flush SHALL clear out_valid and skid_valid at the next edge, discard any same-cycle accept, and take priority over all other events.
REQ-033 Data registers need not change on flush; only valid bits are cleared.

Reset
REQ-034 While rst is high: out_valid = 0, skid_valid = 0, in_ready = 1, alu_op = 0, a = 0, b = 0, illegal = 0.
REQ-035 Reset asserted mid-transfer SHALL discard all held entries immediately, independent of clk.
REQ-036 First accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-037 add: opcode 0, funct 0x20, rs 5, rt 7, out_ready 1 -> next cycle out_valid 1, alu_op 2, a 5, b 7, illegal 0.
REQ-038 addi sign-extend: opcode 0x08, rs 10, imm 16'hFFFF -> alu_op 2, b 32'hFFFFFFFF; ori imm 16'h8000 -> alu_op 1, b 32'h00008000.
REQ-039 Backpressure: out_ready 0, three back-to-back in_valid -> two accepted, in_ready 0 after second; raise out_ready -> both issue in order over two cycles, in_ready returns 1.
REQ-040 Illegal: opcode 0x3F -> alu_op 15, a 0, b 0, illegal 1.
REQ-041 Flush with both entries held and in_valid 1 -> next cycle out_valid 0, in_ready 1, no entry issued.
REQ-042 Async reset pulse between edges with out_valid 1 -> out_valid 0 immediately, all outputs 0.
